// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg : shared 3x3 window constants and element indexing helper
// Rev 1.0
// ============================================================================
package conv_pkg;

  localparam int WIN_K = 3;
  localparam int WIN_N = WIN_K * WIN_K;

  // Flat element index of window row r (0 = oldest line), column c (0 = oldest pixel).
  function automatic logic [3:0] win_idx(input int r, input int c);
    return 4'(WIN_K * r + c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_3x3_if.sv
`default_nettype none
// ============================================================================
// conv_window_3x3_if : pixel stream in, 3x3 window stream out
// Optional o_last under CONV_WINDOW_LAST_EN.  Rev 1.0
// ============================================================================
interface conv_window_3x3_if
  import conv_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic                   i_valid;
  logic [WIDTH-1:0]       i_data;
  logic                   o_valid;
  logic [WIN_N*WIDTH-1:0] o_window;
`ifdef CONV_WINDOW_LAST_EN
  logic                   o_last;
`endif

  modport master (
    output i_valid,
    output i_data,
`ifdef CONV_WINDOW_LAST_EN
    input  o_last,
`endif
    input  o_valid,
    input  o_window
  );

  modport slave (
    input  i_valid,
    input  i_data,
`ifdef CONV_WINDOW_LAST_EN
    output o_last,
`endif
    output o_valid,
    output o_window
  );

endinterface
`default_nettype wire

// File: rtl/conv_line_delay.sv
`default_nettype none
// ============================================================================
// conv_line_delay : DEPTH-accept delay line, circular RAM, read-before-write
// Rev 1.0
// ============================================================================
module conv_line_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // The slot about to be overwritten holds the pixel from DEPTH accepts ago.
  assign o_data = mem_q[ptr_q];

  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (i_valid) begin
      mem_d[ptr_q] = i_data;
      ptr_d        = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_3x3.sv
`default_nettype none
// ============================================================================
// conv_window_3x3 : sliding 3x3 window over a raster pixel stream, no padding
// Optional end-of-frame flag o_last under CONV_WINDOW_LAST_EN.  Rev 1.0
// ============================================================================
module conv_window_3x3
  import conv_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  conv_window_3x3_if.slave  bus
);

  localparam int               COL_W    = $clog2(IMG_W);
  localparam int               ROW_W    = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] win_q [WIN_N];
  logic [WIDTH-1:0] win_d [WIN_N];
  logic [WIDTH-1:0] line_a;
  logic [WIDTH-1:0] line_b;
  logic [WIN_N*WIDTH-1:0] window_flat;

  conv_line_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_line_a (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (bus.i_valid),
    .i_data  (bus.i_data),
    .o_data  (line_a)
  );

  conv_line_delay #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_line_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (bus.i_valid),
    .i_data  (line_a),
    .o_data  (line_b)
  );

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    o_valid_d = 1'b0;
    win_d     = win_q;
    if (bus.i_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      // Position gating also masks stale line-delay data at row/frame starts.
      o_valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      for (int r = 0; r < WIN_K; r++) begin
        win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
        win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
      end
      win_d[win_idx(0, 2)] = line_b;
      win_d[win_idx(1, 2)] = line_a;
      win_d[win_idx(2, 2)] = bus.i_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      col_q     <= '0;
      row_q     <= '0;
      o_valid_q <= 1'b0;
      for (int k = 0; k < WIN_N; k++) win_q[k] <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      o_valid_q <= o_valid_d;
      for (int k = 0; k < WIN_N; k++) win_q[k] <= win_d[k];
    end
  end

  for (genvar k = 0; k < WIN_N; k++) begin : g_flat
    assign window_flat[WIDTH*k +: WIDTH] = win_q[k];
  end

  assign bus.o_valid  = o_valid_q;
  assign bus.o_window = window_flat;

`ifdef CONV_WINDOW_LAST_EN
  logic o_last_q, o_last_d;

  always_comb begin
    o_last_d = bus.i_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) o_last_q <= 1'b0;
    else         o_last_q <= o_last_d;
  end

  assign bus.o_last = o_last_q;
`endif

endmodule
`default_nettype wire
